// File: rtl/rot_buf_arbiter.sv
// Rotation frame-buffer port owner: rotates the incoming pixel stream into column-major
// writes, queues them in a small FIFO, and shares the single RAM port with scanout reads.
module rot_buf_arbiter #(
    parameter int unsigned WIDTH      = 256,
    parameter int unsigned HEIGHT     = 224,
    parameter int unsigned DW         = 8,
    parameter int unsigned AW         = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_in,
    input  logic [DW-1:0] video_in,
    input  logic          hblank,
    input  logic          vblank,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          clr_req,
    output logic          clr_busy,
    input  logic          ovf_clr,
    output logic          overflow,
    output logic          frame_done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam int unsigned XW = $clog2(WIDTH) + 1;
    localparam int unsigned YW = $clog2(HEIGHT) + 1;
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [AW-1:0] LastAddr = AW'(WIDTH * HEIGHT - 1);

    typedef enum logic {StRun, StClear} state_e;

    state_e        state;
    logic [AW-1:0] clr_ptr;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          y_done;
    logic          vblank_q;
    logic          rd_p1;

    logic [AW-1:0] fifo_addr [FIFO_DEPTH];
    logic [DW-1:0] fifo_pix  [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic          active, flush, pop, fifo_full, push_ok, push, drop_ovf, clr_wr;
    logic [AW-1:0] push_addr;

    always_comb begin
        active    = ce_in & ~hblank & ~vblank;
        flush     = (state == StRun) & clr_req;
        pop       = ~rd_req & (state == StRun) & (count != '0);
        fifo_full = (count == CW'(FIFO_DEPTH));
        // Pushes are ignored while clearing, on the clr_req cycle, and past the last line.
        push_ok   = active & (state == StRun) & ~clr_req & ~y_done;
        push      = push_ok & (~fifo_full | pop);
        drop_ovf  = push_ok & fifo_full & ~pop;
        clr_wr    = ~rd_req & (state == StClear);
        push_addr = AW'(x) * AW'(HEIGHT) + AW'(HEIGHT - 1) - AW'(y);
    end

    // Reads win the port outright; otherwise drain the FIFO, otherwise sweep.
    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (rd_req) begin
            ram_addr = rd_addr;
        end else if (pop) begin
            ram_addr = fifo_addr[rd_ptr];
            ram_din  = fifo_pix[rd_ptr];
            ram_we   = 1'b1;
        end else if (clr_wr) begin
            ram_addr = clr_ptr;
            ram_we   = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) begin
            fifo_addr[wr_ptr] <= push_addr;
            fifo_pix[wr_ptr]  <= video_in;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            x      <= '0;
            y      <= '0;
            y_done <= 1'b0;
        end else if (vblank) begin
            x      <= '0;
            y      <= '0;
            y_done <= 1'b0;
        end else if (active) begin
            x <= x + XW'(1);
        end else if (ce_in && hblank && x != '0) begin
            x <= '0;
            if (y == YW'(HEIGHT - 1)) y_done <= 1'b1;
            else                      y      <= y + YW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            frame_done <= 1'b0;
            vblank_q   <= 1'b0;
            rd_p1      <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (drop_ovf)     overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
            frame_done <= vblank & ~vblank_q;
            vblank_q   <= vblank;
            rd_p1      <= rd_req;
            rd_valid   <= rd_p1;
            if (rd_p1) rd_data <= ram_dout;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= StRun;
            clr_ptr  <= '0;
            clr_busy <= 1'b0;
        end else begin
            unique case (state)
                StRun: begin
                    if (clr_req) begin
                        state    <= StClear;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                StClear: begin
                    if (clr_wr) begin
                        if (clr_ptr == LastAddr) begin
                            state    <= StRun;
                            clr_busy <= 1'b0;
                        end else begin
                            clr_ptr <= clr_ptr + AW'(1);
                        end
                    end
                end
                default: state <= StRun;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_buf_arbiter.sv
// Randomized bench for rot_buf_arbiter against a queue-based transaction model.
module tb_rot_buf_arbiter;

    localparam int W = 256;
    localparam int H = 224;
    localparam int DEPTH = 4;
    localparam int NPIX = W * H;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce_in = 1'b0;
    logic [7:0]  video_in = '0;
    logic        hblank = 1'b0;
    logic        vblank = 1'b0;
    logic        rd_req = 1'b0;
    logic [15:0] rd_addr = '0;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        ovf_clr = 1'b0;
    logic        overflow;
    logic        frame_done;
    logic [15:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout = '0;

    always #5 clk_sys = ~clk_sys;

    rot_buf_arbiter #(
        .WIDTH(W), .HEIGHT(H), .DW(8), .AW(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_in(ce_in), .video_in(video_in),
        .hblank(hblank), .vblank(vblank), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_valid(rd_valid), .rd_data(rd_data), .clr_req(clr_req), .clr_busy(clr_busy),
        .ovf_clr(ovf_clr), .overflow(overflow), .frame_done(frame_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // RAM stand-in: returns a fixed function of the address (100 -> 0xA5).
    function automatic logic [7:0] ram_fn(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC1;
    endfunction

    always @(posedge clk_sys) ram_dout <= ram_fn(ram_addr);

    int     n_checks = 0;
    int     n_pass = 0;
    longint cyc = 0;
    bit     chk_en = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    typedef struct {int addr; int pix;} wr_t;
    typedef struct {longint due; int data;} rd_t;

    wr_t q[$];
    rd_t rdq[$];
    int  mx, my, mptr;
    bit  mydone, mclear, movf, mfd, mvbq;

    task automatic step();
        bit pop, cw, was_clear, set_ovf, exp_rv;
        @(negedge clk_sys);
        pop = !rd_req && !mclear && q.size() > 0;
        cw  = !rd_req && mclear;
        exp_rv = rdq.size() > 0 && rdq[0].due == cyc;
        if (chk_en) begin
            check_val("ram_we", 32'(ram_we), 32'(pop || cw));
            if (rd_req) begin
                check_val("rd_port_addr", 32'(ram_addr), 32'(rd_addr));
            end else if (pop) begin
                check_val("wr_addr", 32'(ram_addr), 32'(q[0].addr));
                check_val("wr_data", 32'(ram_din), 32'(q[0].pix));
            end else if (cw) begin
                check_val("clr_addr", 32'(ram_addr), 32'(mptr));
                check_val("clr_data", 32'(ram_din), 32'd0);
            end
            check_val("rd_valid", 32'(rd_valid), 32'(exp_rv));
            if (exp_rv) check_val("rd_data", 32'(rd_data), 32'(rdq[0].data));
            check_val("overflow", 32'(overflow), 32'(movf));
            check_val("frame_done", 32'(frame_done), 32'(mfd));
            check_val("clr_busy", 32'(clr_busy), 32'(mclear));
        end
        if (exp_rv) void'(rdq.pop_front());

        if (!reset_n) begin
            q.delete(); rdq.delete();
            mx = 0; my = 0; mptr = 0;
            mydone = 0; mclear = 0; movf = 0; mfd = 0; mvbq = 0;
        end else begin
            was_clear = mclear;
            set_ovf = 0;
            if (pop) void'(q.pop_front());
            if (rd_req) rdq.push_back('{cyc + 2, int'(ram_fn(rd_addr))});
            if (cw) begin
                if (mptr == NPIX - 1) mclear = 0;
                else mptr++;
            end
            if (vblank) begin
                mx = 0; my = 0; mydone = 0;
            end else if (ce_in && !hblank) begin
                if (!was_clear && !clr_req && !mydone) begin
                    if (q.size() < DEPTH) q.push_back('{(mx * H + H - 1 - my) % 65536,
                                                       int'(video_in)});
                    else set_ovf = 1;
                end
                mx++;
            end else if (ce_in && hblank && mx != 0) begin
                mx = 0;
                if (my == H - 1) mydone = 1;
                else my++;
            end
            if (!was_clear && clr_req) begin
                mclear = 1; mptr = 0; q.delete();
            end
            if (set_ovf) movf = 1;
            else if (ovf_clr) movf = 0;
            mfd = vblank && !mvbq;
            mvbq = vblank;
        end
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic drive(input bit ce, input logic [7:0] v, input bit hb, input bit vb,
                         input bit rr, input logic [15:0] ra, input bit cr, input bit oc);
        ce_in = ce; video_in = v; hblank = hb; vblank = vb;
        rd_req = rr; rd_addr = ra; clr_req = cr; ovf_clr = oc;
        step();
    endtask

    task automatic drive_random(input bit allow_clr);
        bit hb;
        hb = (mx >= 24) || ($urandom % 12 == 0);
        drive($urandom % 4 != 0, 8'($urandom), hb, $urandom % 150 == 0,
              $urandom % 5 == 0, 16'($urandom), allow_clr && ($urandom % 500 == 0),
              $urandom % 40 == 0);
    endtask

    initial begin
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk_en = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // One short line: writes land at 223, 447, 671.
        drive(1, 8'h11, 0, 0, 0, 0, 0, 0);
        drive(1, 8'h22, 0, 0, 0, 0, 0, 0);
        drive(1, 8'h33, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Read while a write is pending.
        drive(1, 8'h44, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 16'd100, 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Starved port: 6 pushes into a 4-deep FIFO, then clear the flag and drain.
        for (int i = 0; i < 10; i++)
            drive(i < 6, 8'(8'h50 + i), 0, 0, 1, 16'(i * 7), 0, 0);
        drive(0, 0, 0, 0, 1, 16'd3, 0, 1);
        repeat (7) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Full FIFO with simultaneous pop and push: no overflow.
        for (int i = 0; i < 4; i++) drive(1, 8'(i), 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, 8'(8'hE0 + i), 0, 0, 0, 0, 0, 0);
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // vblank rising edge, then the next pixel goes to (0,0).
        drive(1, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 0, 0, 0, 0);
        drive(1, 8'h77, 0, 0, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) drive_random(0);
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Full clear sweep with occasional reads and discarded pixels.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 70000 && mclear; i++)
            drive($urandom % 8 == 0, 8'($urandom), 0, 0, $urandom % 64 == 0,
                  16'($urandom), $urandom % 1000 == 0, 0);
        repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset mid-sweep with a read in flight.
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        repeat (50) drive(0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 16'd100, 0, 0);
        reset_n = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1;
        repeat (5) drive(0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 500; i++) drive_random(0);
        repeat (6) drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rot_buf_arbiter.md
Name: rot_buf_arbiter

Overview:
- Owns the single-port rotation frame buffer between the core's pixel stream and the HDMI scanout reader.
- Converts the incoming 256x224 pixel stream (ce-qualified, with blanks) into rotated, column-major write addresses.
- Queues the writes in a small FIFO and shares the RAM port with scanout reads; reads have fixed latency and absolute priority.
- Also sequences a full-buffer clear sweep on request.

Parameters:
- WIDTH, 256, active pixels per input line
- HEIGHT, 224, active input lines per frame
- DW, 8, pixel width ({r,g,b} = 3+3+2)
- AW, 16, RAM address width; must satisfy WIDTH*HEIGHT <= 2^AW
- FIFO_DEPTH, 4, write FIFO entries (power of 2)

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- ce_in  in  1  input pixel enable
- video_in  in  DW  input pixel
- hblank  in  1  input horizontal blank
- vblank  in  1  input vertical blank
- rd_req  in  1  scanout read request, single-cycle
- rd_addr  in  AW  scanout read address
- rd_valid  out  1  read data valid
- rd_data  out  DW  read data
- clr_req  in  1  start clear sweep, pulse
- clr_busy  out  1  clear sweep in progress
- ovf_clr  in  1  clear overflow flag
- overflow  out  1  sticky: a pixel was dropped because the FIFO was full
- frame_done  out  1  one-cycle pulse on vblank rising edge
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid 1 cycle after ram_addr

Behaviour:
- Reset (reset_n=0 at a clk_sys edge):
  - Outputs: rd_valid=0, rd_data=0, clr_busy=0, overflow=0, frame_done=0, ram_we=0, ram_addr=0, ram_din=0.
  - Internal: FIFO emptied, x=0, y=0, state=RUN.
  - Reset mid-sweep or mid-read aborts it; no pending rd_valid is produced afterwards.
- Pixel capture:
  - Push condition: ce_in & ~hblank & ~vblank pushes {addr, video_in}, with addr = x*HEIGHT + (HEIGHT-1-y).
  - After each push, x increments.
  - On ce_in & hblank with x!=0: x<=0 and y<=y+1.
  - If y reaches HEIGHT, it saturates at HEIGHT-1 and further pushes are dropped.
  - On vblank: x<=0, y<=0.
  - frame_done pulses for 1 cycle on the first cycle vblank is seen high after being low.
- FIFO:
  - Push onto a full FIFO drops the pixel and sets overflow.
  - overflow stays set until ovf_clr.
  - Set and clear in the same cycle: set wins.
  - Simultaneous push and pop on a full FIFO is allowed and does not overflow.
- Port arbitration, evaluated each cycle:
  - rd_req=1: ram_addr=rd_addr, ram_we=0. rd_valid=1 and rd_data=ram_dout exactly 2 cycles after rd_req (registered); rd_valid is 1 cycle wide.
  - Else, in state RUN with the FIFO non-empty: pop the head; ram_addr=entry.addr, ram_din=entry.pixel, ram_we=1.
  - Else, in state CLEAR: ram_addr=clr_ptr, ram_din=0, ram_we=1, clr_ptr++.
  - Otherwise ram_we=0.
  - A continuous rd_req stream starves writes; this is permitted and is reported only via overflow.
- State machine:
  - RUN -> CLEAR on clr_req: clr_ptr=0, clr_busy=1, and the FIFO is flushed.
  - In CLEAR, pixel pushes are discarded and do not set overflow.
  - CLEAR -> RUN after the write to address WIDTH*HEIGHT-1; clr_busy falls the cycle after that write.
  - clr_req while already in CLEAR is ignored.
  - Reads stay serviced during CLEAR with the same latency.
- Widths and counters:
  - x is log2(WIDTH)+1 bits and y is log2(HEIGHT)+1 bits.
  - Address arithmetic is truncated to AW bits.
  - clr_ptr saturates; there is no wrap.

Test Plan:
- Reset, then one line of 3 pixels 0x11,0x22,0x33 with hblank/vblank low and the port idle -> ram_we writes at addresses 223, 447, 671 with those data in order, each within 1 cycle of its push.
- rd_req at cycle N with rd_addr=100, RAM model returning 0xA5 -> rd_valid=1 and rd_data=0xA5 at N+2 only; ram_we=0 at N even with the FIFO non-empty.
- rd_req held high for 10 cycles while 6 pixels are pushed -> first 4 pixels queued, 5th and 6th dropped, overflow=1; ovf_clr asserted -> overflow=0; after rd_req drops, 4 writes drain.
- clr_req with the port idle -> clr_busy high for 57344 cycles, writes of 0 to addresses 0..57343, then RUN; a rd_req mid-sweep returns data at +2 and delays the sweep by one cycle.
- vblank rising -> frame_done single pulse; the next active pixel is written to address 223 (x=0, y=0).
- reset_n low during CLEAR and with an outstanding read -> next cycle clr_busy=0, ram_we=0, and no rd_valid ever appears for that read.
